// File: rtl/wall_pkg.sv
// Shared screen geometry, colours and FSM encodings for the wall drawer.
package wall_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BG   = 3'b000;
    localparam logic [2:0] WALL = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ERASE = 2'b01,
        ST_DRAW  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Hole bottom row (exclusive), clamped to the screen height.
    function automatic logic [8:0] hole_bottom(input logic [8:0] top,
                                               input logic [8:0] height,
                                               input logic [8:0] limit);
        logic [8:0] sum;
        sum = top + height;
        return (sum > limit) ? limit : sum;
    endfunction

endpackage

// File: rtl/wall_drawer_pixel_scanner.sv
// Column/row scan counter: rows sweep fastest, columns step on row wrap.
module pixel_scanner #(
    parameter int WALL_W   = 4,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_en,
    input  logic       i_clr,
    output logic [7:0] o_col,
    output logic [7:0] o_row,
    output logic       o_last
);

    logic [7:0] r_col;
    logic [7:0] r_row;
    logic       w_row_end;
    logic       w_col_end;

    assign w_row_end = (r_row == 8'(SCREEN_H - 1));
    assign w_col_end = (r_col == 8'(WALL_W - 1));
    assign o_col     = r_col;
    assign o_row     = r_row;
    assign o_last    = w_row_end && w_col_end;

    // Scan position; clear wins over enable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_col <= 8'd0;
            r_row <= 8'd0;
        end else if (i_clr) begin
            r_col <= 8'd0;
            r_row <= 8'd0;
        end else if (i_en) begin
            if (w_row_end) begin
                r_row <= 8'd0;
                r_col <= w_col_end ? 8'd0 : r_col + 8'd1;
            end else begin
                r_row <= r_row + 8'd1;
            end
        end
    end

endmodule

// File: rtl/wall_drawer.sv
// Redraws a vertical wall with a hole, one pixel per cycle, on start.
// Define WALL_DRAWER_ERASE_EN to erase the previous wall before drawing.
module wall_drawer #(
    parameter int WALL_W   = 4,
    parameter int SCREEN_W = wall_pkg::SCREEN_W,
    parameter int SCREEN_H = wall_pkg::SCREEN_H,
    parameter int HOLE_H   = 40
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] wall_x,
    input  logic [7:0] hole_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    import wall_pkg::*;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_new_x;
    logic [7:0] r_new_y;
    logic       w_latch;
    logic       w_scan_en;
    logic       w_scan_clr;
    logic [7:0] w_col;
    logic [7:0] w_row;
    logic       w_last;
    logic [7:0] w_base_x;
    logic [8:0] w_px_x;
    logic       w_px_valid;
    logic [2:0] w_px_colour;
    logic [8:0] w_hole_bot;
    logic       w_in_hole;
`ifdef WALL_DRAWER_ERASE_EN
    logic [7:0] r_old_x;
    logic       r_have_wall;
`endif

    pixel_scanner #(
        .WALL_W   (WALL_W),
        .SCREEN_H (SCREEN_H)
    ) u_scanner (
        .clk    (clk),
        .resetn (resetn),
        .i_en   (w_scan_en),
        .i_clr  (w_scan_clr),
        .o_col  (w_col),
        .o_row  (w_row),
        .o_last (w_last)
    );

    assign w_px_x     = {1'b0, w_base_x} + {1'b0, w_col};
    assign w_hole_bot = hole_bottom({1'b0, r_new_y}, 9'(HOLE_H), 9'(SCREEN_H));
    assign w_in_hole  = ({1'b0, w_row} >= {1'b0, r_new_y}) && ({1'b0, w_row} < w_hole_bot);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, scanner control and the pixel about to be registered.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_scan_en    = 1'b0;
        w_scan_clr   = 1'b0;
        w_base_x     = r_new_x;
        w_px_valid   = 1'b0;
        w_px_colour  = BG;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_latch    = 1'b1;
                    w_scan_clr = 1'b1;
`ifdef WALL_DRAWER_ERASE_EN
                    w_next_state = r_have_wall ? ST_ERASE : ST_DRAW;
`else
                    w_next_state = ST_DRAW;
`endif
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
`ifdef WALL_DRAWER_ERASE_EN
            ST_ERASE: begin
                w_base_x   = r_old_x;
                w_px_valid = 1'b1;
                w_scan_en  = 1'b1;
                if (w_last) begin
                    w_scan_clr   = 1'b1;
                    w_next_state = ST_DRAW;
                end else begin
                    w_next_state = ST_ERASE;
                end
            end
`endif
            ST_DRAW: begin
                w_px_valid  = 1'b1;
                w_px_colour = w_in_hole ? BG : WALL;
                w_scan_en   = 1'b1;
                if (w_last) begin
                    w_scan_clr   = 1'b1;
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_DRAW;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Target wall position, captured only when a start is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_new_x <= 8'd0;
            r_new_y <= 8'd0;
        end else if (w_latch) begin
            r_new_x <= wall_x;
            r_new_y <= hole_y;
        end
    end

`ifdef WALL_DRAWER_ERASE_EN
    // Remember the finished wall so the next frame can erase it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_old_x     <= 8'd0;
            r_have_wall <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_old_x     <= r_new_x;
            r_have_wall <= 1'b1;
        end
    end
`endif

    // Registered VGA outputs; off-screen columns are scanned but not plotted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x      <= 8'd0;
            y      <= 7'd0;
            colour <= 3'd0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            x      <= w_px_x[7:0];
            y      <= w_row[6:0];
            colour <= w_px_colour;
            plot   <= w_px_valid && (w_px_x < 9'(SCREEN_W));
            busy   <= (r_state != ST_IDLE);
            done   <= (r_state == ST_DONE);
        end
    end

endmodule

// File: tb/tb_wall_drawer.sv
// Self-checking bench for wall_drawer: frame table plus a pixel-list reference model.
module tb_wall_drawer;

    localparam int WALL_W   = 4;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int HOLE_H   = 40;
`ifdef WALL_DRAWER_ERASE_EN
    localparam bit ERASE_EN = 1'b1;
`else
    localparam bit ERASE_EN = 1'b0;
`endif
    localparam int T_FIRST = 481;
    localparam int T_NEXT  = ERASE_EN ? 961 : 481;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [7:0] wall_x;
    logic [7:0] hole_y;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    wall_drawer #(
        .WALL_W   (WALL_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .HOLE_H   (HOLE_H)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .wall_x (wall_x),
        .hole_y (hole_y),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    typedef struct {
        logic [7:0] wx;
        logic [7:0] hy;
        int         pa;
        int         pb;
        int         abort_at;
        int         exp_done;
    } vec_t;

    pix_t exp_q[$];
    pix_t got_q[$];
    vec_t vecs[9];
    int   errors = 0;
    int   checks = 0;
    bit   m_have = 1'b0;
    int   m_old_x = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic logic [31:0] outs_word();
        return 32'({x, y, colour, plot, busy, done});
    endfunction

    // Reference: every visible pixel of one wall, in column-then-row order.
    function automatic void push_wall(input int base, input bit draw, input int hy);
        for (int c = 0; c < WALL_W; c++) begin
            for (int r = 0; r < SCREEN_H; r++) begin
                if (base + c < SCREEN_W) begin
                    pix_t p;
                    p.px = 8'(base + c);
                    p.py = 7'(r);
                    p.pc = (draw && !(r >= hy && r < hy + HOLE_H)) ? 3'b010 : 3'b000;
                    exp_q.push_back(p);
                end
            end
        end
    endfunction

    task automatic run_frame(input string tag, input vec_t v);
        int done_cnt;
        int done_cyc;
        int busy_err;
        int mism;
        int lim;
        bit aborted;
        exp_q.delete();
        got_q.delete();
        if (ERASE_EN && m_have) push_wall(m_old_x, 1'b0, 0);
        push_wall(int'(v.wx), 1'b1, int'(v.hy));
        done_cnt = 0;
        done_cyc = -1;
        busy_err = 0;
        aborted  = 1'b0;
        lim      = v.exp_done + 2;
        @(negedge clk);
        start  = 1'b1;
        wall_x = v.wx;
        hole_y = v.hy;
        for (int cyc = 0; cyc <= lim && !aborted; cyc++) begin
            @(negedge clk);
            start  = (cyc == v.pa) || (cyc == v.pb);
            wall_x = 8'($urandom);
            hole_y = 8'($urandom);
            if (cyc == v.abort_at) begin
                resetn = 1'b0;
                #1;
                check({tag, " outputs at reset"}, outs_word(), 32'd0);
                aborted = 1'b1;
            end else begin
                if (plot === 1'b1) got_q.push_back({x, y, colour});
                if (done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (busy !== ((cyc >= 1) && (cyc <= v.exp_done))) busy_err++;
            end
        end
        start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            check({tag, " outputs held in reset"}, outs_word(), 32'd0);
            check({tag, " done before abort"}, done_cnt, 32'd0);
            resetn = 1'b1;
            m_have = 1'b0;
        end else begin
            mism = -1;
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                if (mism < 0 && got_q[i] !== exp_q[i]) mism = i;
            end
            check({tag, " plot count"}, got_q.size(), exp_q.size());
            check({tag, " first bad pixel index+1"}, mism + 1, 32'd0);
            check({tag, " done pulses"}, done_cnt, 32'd1);
            check({tag, " done cycle"}, done_cyc, v.exp_done);
            check({tag, " busy errors"}, busy_err, 32'd0);
            m_have  = 1'b1;
            m_old_x = int'(v.wx);
        end
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        wall_x = 8'd0;
        hole_y = 8'd0;

        vecs[0] = '{8'd100, 8'd30,  -1, -1,  -1, T_FIRST};
        vecs[1] = '{8'd96,  8'd34,  -1, -1,  -1, T_NEXT};
        vecs[2] = '{8'd158, 8'd100, -1, -1,  -1, T_NEXT};
        vecs[3] = '{8'd20,  8'd200,  5, 200, -1, T_NEXT};
        vecs[4] = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1, -1, -1, T_NEXT};
        vecs[5] = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1, -1, -1, T_NEXT};
        vecs[6] = '{8'($urandom_range(0, 159)), 8'($urandom_range(0, 119)), 17, -1, -1, T_NEXT};
        vecs[7] = '{8'd50,  8'd10,  -1, -1, (ERASE_EN ? 480 : 0) + 300, T_NEXT};
        vecs[8] = '{8'd60,  8'd0,   -1, -1,  -1, T_FIRST};

        repeat (3) @(negedge clk);
        check("outputs in reset", outs_word(), 32'd0);
        resetn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle after reset", 32'({plot, busy, done}), 32'd0);
        end

        for (int i = 0; i < 9; i++) begin
            run_frame($sformatf("frame%0d", i), vecs[i]);
        end

        start = 1'b0;
        repeat (10) @(negedge clk);
        check("idle after frames", 32'({plot, busy, done}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wall_drawer.md
WALL_DRAWER -- requirements
Module: wall_drawer

Interface
REQ-001 Parameter WALL_W, default 4: wall thickness in pixels (columns).
REQ-002 Parameter SCREEN_W, default 160: screen width in pixels.
REQ-003 Parameter SCREEN_H, default 120: screen height in pixels; also the wall height.
REQ-004 Parameter HOLE_H, default 40: vertical hole size in pixels.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request to redraw the wall; sampled only in IDLE.
REQ-008 wall_x  input  8  new wall left column.
REQ-009 hole_y  input  8  new hole top row.
REQ-010 x  output  8  pixel column to the VGA adapter.
REQ-011 y  output  7  pixel row to the VGA adapter.
REQ-012 colour  output  3  pixel colour to the VGA adapter.
REQ-013 plot  output  1  write strobe; pixel (x, y, colour) is valid when high.
REQ-014 busy  output  1  high from the cycle after start is accepted until done.
REQ-015 done  output  1  one-cycle pulse when the frame update completes.

Function
REQ-016 FSM states: IDLE, ERASE, DRAW, DONE; 2-bit encoding.
REQ-017 IDLE with start=1: latch wall_x/hole_y into new_x/new_y; go to ERASE if a previous wall exists, else DRAW.
REQ-018 start while busy is ignored; latched inputs are unaffected.
REQ-019 ERASE: scan col 0..WALL_W-1 (outer), row 0..SCREEN_H-1 (inner) at old_x; one pixel per cycle, colour = background (3'b000).
REQ-020 DRAW: same scan order at new_x; colour = background if new_y <= row < new_y+HOLE_H, else wall colour (3'b010).
REQ-021 Hole bottom saturates at SCREEN_H; hole_y >= SCREEN_H yields a solid wall.
REQ-022 Column clipping: pixels with base_x+col >= SCREEN_W are scanned but plot=0 (no wrap-around to column 0).
REQ-023 Hole arithmetic uses 9 bits; no truncation overflow.
REQ-024 Last DRAW pixel -> DONE: done=1 for one cycle; old_x <= new_x; previous-wall flag set; next state IDLE.
REQ-025 Latency, start accepted at cycle 0: first plot at cycle 1; done at cycle 1 + 2*WALL_W*SCREEN_H with erase (961 cycles at defaults), or 1 + WALL_W*SCREEN_H without (481).
REQ-026 plot=0, done=0 and busy=0 in IDLE.
REQ-027 y = low 7 bits of the row counter.

Reset
REQ-028 resetn low forces at once: state IDLE; counters, old_x, new_x and new_y = 0; previous-wall flag = 0.
REQ-029 Outputs under reset: x=0, y=0, colour=0, plot=0, busy=0, done=0.
REQ-030 Reset mid-ERASE/DRAW aborts the frame with no done pulse; the next frame does no erase.

Configuration
REQ-031 Macro WALL_DRAWER_ERASE_EN defined: ERASE phase as in REQ-017/019.
REQ-032 Macro absent: ERASE state and old_x not built; IDLE goes straight to DRAW; the screen clear is the caller's responsibility.

Structure
REQ-033 Package wall_pkg holds SCREEN_W, SCREEN_H, the colour constants (BG, WALL) and the FSM state encodings; it is shared with the wall datapath.
REQ-034 One sub-module, pixel_scanner: col/row counter with enable, clear and a last-pixel flag; instanced once and reused by ERASE and DRAW.

Verification
REQ-035 Reset, then start with wall_x=100, hole_y=30 -> no ERASE; 480 plots at x 100..103; rows 30..69 BG, all other rows WALL; done at cycle 481.
REQ-036 Second start with wall_x=96, hole_y=34 -> 480 BG plots at x 100..103, then DRAW at x 96..99; done at cycle 961.
REQ-037 wall_x=158 -> columns 160 and 161 scanned with plot=0; only x 158..159 plotted; done timing unchanged.
REQ-038 hole_y=100 -> rows 100..119 BG; hole_y=200 -> solid wall in every row.
REQ-039 start pulses at cycles 5 and 200 of a frame -> ignored; latched values unchanged; exactly one done.
REQ-040 resetn low at cycle 300 of DRAW -> all outputs 0 immediately; no done; next start draws with no erase.
